// File: rtl/core_mem_pkg.sv
// Shared types and address helpers for the dual-channel memory controller.
package core_mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_e;

    function automatic logic [63:0] word_index(input logic [63:0] addr,
                                               input logic [63:0] base,
                                               input int unsigned shift);
        return (addr - base) >> shift;
    endfunction

    // Subtraction is only trusted once addr >= base, so low addresses cannot wrap in.
    function automatic logic in_range(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [63:0] span);
        return (addr >= base) && ((addr - base) < span);
    endfunction

endpackage

// File: rtl/core_mem_rr_arb.sv
// Two-way round-robin arbiter; req[0] is fetch, req[1] is data.
module core_mem_rr_arb
    import core_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output port_e      grant
);

    port_e last_q, last_d;

    always_comb begin
        grant = PORT_D;
        if (req[0] && req[1]) begin
            grant = (last_q == PORT_D) ? PORT_I : PORT_D;
        end else if (req[0]) begin
            grant = PORT_I;
        end
        last_d = accept ? grant : last_q;
    end

    // Resetting to "last was fetch" makes data win the first collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_q <= PORT_I;
        else       last_q <= last_d;
    end

endmodule

// File: rtl/core_mem_ctrl.sv
// Dual-channel (fetch/data) controller for one shared word RAM with wait states.
// Define CORE_MEM_ACCESS_ERR_EN to add i_err/d_err access-error outputs.
module core_mem_ctrl
    import core_mem_pkg::*;
#(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned DEPTH     = 4096,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int unsigned LATENCY   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_valid,
    input  logic [63:0]         i_addr,
    output logic                i_ready,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_valid,
    input  logic                d_wen,
    input  logic [63:0]         d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_ready,
    output logic [DATA_W-1:0]   d_rdata
`ifdef CORE_MEM_ACCESS_ERR_EN
    ,
    output logic                i_err,
    output logic                d_err
`endif
);

    localparam int unsigned NB       = DATA_W / 8;
    localparam int unsigned OFS_W    = $clog2(NB);
    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam logic [63:0] SPAN     = 64'(DEPTH) * 64'(NB);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    port_e             port_q, port_d;
    logic              wen_q, wen_d;
    logic [63:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NB-1:0]     wstrb_q, wstrb_d;
    logic              i_ready_q, i_ready_d, d_ready_q, d_ready_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

    logic [DATA_W-1:0] mem [DEPTH];

    port_e             grant;
    logic              accept, commit, op_ok;
    logic [IDX_W-1:0]  op_idx;
    logic [DATA_W-1:0] op_rdata;

    // RESP is the ready cycle, so IDLE never overlaps a ready pulse; the check is kept explicit.
    assign accept = (state_q == IDLE) && (i_valid || d_valid) && !i_ready_q && !d_ready_q;

    core_mem_rr_arb u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    ({d_valid, i_valid}),
        .accept (accept),
        .grant  (grant)
    );

    // The *_d request fields are the operation committed at this edge
    // (live request when LATENCY=1, otherwise the latched copy).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        port_d    = port_q;
        wen_d     = wen_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        commit    = 1'b0;
        unique case (state_q)
            IDLE: if (accept) begin
                port_d  = grant;
                wen_d   = (grant == PORT_D) && d_wen;
                addr_d  = (grant == PORT_D) ? d_addr : i_addr;
                wdata_d = d_wdata;
                wstrb_d = d_wstrb;
                cnt_d   = CNT_INIT;
                if (LATENCY == 1) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        op_ok = in_range(addr_d, BASE_ADDR, SPAN);
`ifdef CORE_MEM_ACCESS_ERR_EN
        if ((port_d == PORT_I) && (addr_d[1:0] != 2'b00)) op_ok = 1'b0;
`endif
        op_idx   = IDX_W'(word_index(addr_d, BASE_ADDR, OFS_W));
        op_rdata = op_ok ? mem[op_idx] : '0;

        i_ready_d = commit && (port_d == PORT_I);
        d_ready_d = commit && (port_d == PORT_D);
        if (i_ready_d)           i_rdata_d = op_rdata;
        if (d_ready_d && !wen_d) d_rdata_d = op_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            port_q    <= PORT_D;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            port_q    <= port_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // RAM is not reset; a reset at the commit edge drops the write.
    always_ff @(posedge clk) begin
        if (commit && !reset && wen_d && op_ok) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (wstrb_d[b]) mem[op_idx][b*8 +: 8] <= wdata_d[b*8 +: 8];
            end
        end
    end

    assign i_ready = i_ready_q;
    assign d_ready = d_ready_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

`ifdef CORE_MEM_ACCESS_ERR_EN
    logic i_err_q, i_err_d, d_err_q, d_err_d;

    always_comb begin
        i_err_d = i_ready_d && !op_ok;
        d_err_d = d_ready_d && !op_ok;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_err_q <= 1'b0;
            d_err_q <= 1'b0;
        end else begin
            i_err_q <= i_err_d;
            d_err_q <= d_err_d;
        end
    end

    assign i_err = i_err_q;
    assign d_err = d_err_q;
`endif

endmodule
